// File: rtl/line_buffer_pkg.sv
// Shared types and width helpers for the multi-channel vertical line buffer.
package line_buffer_pkg;

  typedef enum logic [1:0] {
    PAD_NONE = 2'd0,
    PAD_ZERO = 2'd1,
    PAD_REPL = 2'd2
  } pad_mode_e;

  function automatic int pix_w(int data_w, int channels);
    return data_w * channels;
  endfunction

  function automatic int clog2w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Encoding 3 is reserved and behaves as zero padding.
  function automatic pad_mode_e decode_pad(logic [1:0] m);
    case (m)
      2'd0:    return PAD_NONE;
      2'd2:    return PAD_REPL;
      default: return PAD_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/line_buffer_mc_if.sv
// Pixel-in / window-out handshake bundle of the line buffer.
interface line_buffer_mc_if import line_buffer_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int KERNEL_H = 7
);
  localparam int PIX_W = pix_w(DATA_W, CHANNELS);

  logic [1:0]                i_pad_mode;
  logic                      i_vld;
  logic                      i_eor;
  logic                      i_eof;
  logic [PIX_W-1:0]          i_data;
  logic                      o_rdy;
  logic                      i_rdy;
  logic                      o_vld;
  logic                      o_eor;
  logic                      o_eof;
  logic                      o_ovf;
  logic [KERNEL_H*PIX_W-1:0] o_data;

  modport slave (
    input  i_pad_mode, i_vld, i_eor, i_eof, i_data, i_rdy,
    output o_rdy, o_vld, o_eor, o_eof, o_ovf, o_data
  );

  modport master (
    output i_pad_mode, i_vld, i_eor, i_eof, i_data, i_rdy,
    input  o_rdy, o_vld, o_eor, o_eof, o_ovf, o_data
  );
endinterface

// File: rtl/line_buffer_pad_mux.sv
// Rotates bank outputs into row-age order and substitutes top-edge padding.
module line_buffer_pad_mux import line_buffer_pkg::*; #(
  parameter int PIX_W    = 24,
  parameter int KERNEL_H = 7,
  parameter int PTR_W    = 3
) (
  input  logic [KERNEL_H-1:0][PIX_W-1:0] i_bank,
  input  logic [PIX_W-1:0]               i_cur,
  input  logic [PTR_W-1:0]               i_row,
  input  logic [PTR_W-1:0]               i_done,
  input  pad_mode_e                      i_mode,
  output logic [KERNEL_H-1:0][PIX_W-1:0] o_win
);
  function automatic logic [PTR_W-1:0] age_bank(int row, int age);
    int t;
    t = row + KERNEL_H - age;
    return PTR_W'((t >= KERNEL_H) ? t - KERNEL_H : t);
  endfunction

  logic [PIX_W-1:0] repl;

  always_comb begin
    // Oldest real row; with no completed rows that is the current pixel itself.
    repl = (i_done == '0) ? i_cur : i_bank[age_bank(int'(i_row), int'(i_done))];
    o_win = '0;
    o_win[KERNEL_H-1] = i_cur;
    for (int j = 1; j < KERNEL_H; j++) begin
      if (j <= int'(i_done))
        o_win[KERNEL_H-1-j] = i_bank[age_bank(int'(i_row), j)];
      else if (i_mode == PAD_REPL)
        o_win[KERNEL_H-1-j] = repl;
    end
  end
endmodule

// File: rtl/row_bank.sv
// One row of pixel storage: simple dual-port RAM, registered read held when idle.
module row_bank #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 640,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_raddr];
  end
endmodule

// File: rtl/skid_buffer.sv
// Fall-through skid buffer: one spare entry, registered upstream ready.
module skid_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_rdy,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_rdy
);
  logic              sk_vld, sk_nxt;
  logic [DATA_W-1:0] sk_data;
  logic              in_fire;

  assign in_fire = i_vld && o_rdy;
  assign o_vld   = sk_vld || in_fire;
  assign o_data  = sk_vld ? sk_data : i_data;

  always_comb begin
    sk_nxt = sk_vld;
    if (sk_vld) begin
      if (i_rdy) sk_nxt = 1'b0;
    end else if (in_fire && !i_rdy) begin
      sk_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sk_vld <= 1'b0;
      o_rdy  <= 1'b0;
    end else begin
      sk_vld <= sk_nxt;
      o_rdy  <= !sk_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!sk_vld && in_fire && !i_rdy) sk_data <= i_data;
  end
endmodule

// File: rtl/line_buffer_mc.sv
// Multi-channel vertical line buffer: one KERNEL_H-tall column window per pixel.
module line_buffer_mc import line_buffer_pkg::*; #(
  parameter int DATA_W    = 8,
  parameter int CHANNELS  = 3,
  parameter int KERNEL_H  = 7,
  parameter int MAX_IMG_W = 640
) (
  input logic            i_clk,
  input logic            i_rst_n,
  line_buffer_mc_if.slave bus
);
  localparam int PIX_W = pix_w(DATA_W, CHANNELS);
  localparam int PTR_W = clog2w(KERNEL_H);
  localparam int COL_W = clog2w(MAX_IMG_W);

  logic                          sb_vld, sb_rdy, sb_eor, sb_eof;
  logic [PIX_W+1:0]              sb_data;
  logic [PIX_W-1:0]              sb_pix;
  logic                          acc, row_end, frame_start, emit;
  pad_mode_e                     mode_eff, mode_q;
  logic [COL_W-1:0]              col_q;
  logic                          col_full_q;
  logic [PTR_W-1:0]              wr_row_q, rows_done_q, win_row_q, win_done_q;
  logic [PIX_W-1:0]              cur_q;
  logic                          vld_q, eor_q, eof_q, ovf_q;
  logic [KERNEL_H-1:0][PIX_W-1:0] bank_rd, win;

  skid_buffer #(.DATA_W(PIX_W+2)) u_skid (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_vld  (bus.i_vld),
    .i_data ({bus.i_eof, bus.i_eor, bus.i_data}),
    .o_rdy  (bus.o_rdy),
    .o_vld  (sb_vld),
    .o_data (sb_data),
    .i_rdy  (sb_rdy)
  );

  assign {sb_eof, sb_eor, sb_pix} = sb_data;
  assign sb_rdy      = !vld_q || bus.i_rdy;
  assign acc         = sb_vld && sb_rdy;
  assign row_end     = sb_eor || sb_eof;
  assign frame_start = (col_q == '0) && !col_full_q && (rows_done_q == '0);
  assign mode_eff    = frame_start ? decode_pad(bus.i_pad_mode) : mode_q;
  assign emit        = (mode_eff != PAD_NONE) || (rows_done_q == PTR_W'(KERNEL_H-1));

  for (genvar b = 0; b < KERNEL_H; b++) begin : g_bank
    row_bank #(.WIDTH(PIX_W), .DEPTH(MAX_IMG_W)) u_bank (
      .i_clk  (i_clk),
      .i_we   (acc && (wr_row_q == PTR_W'(b))),
      .i_waddr(col_q),
      .i_wdata(sb_pix),
      .i_re   (acc),
      .i_raddr(col_q),
      .o_rdata(bank_rd[b])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q       <= '0;
      col_full_q  <= 1'b0;
      wr_row_q    <= '0;
      rows_done_q <= '0;
      win_row_q   <= '0;
      win_done_q  <= '0;
      mode_q      <= PAD_NONE;
      cur_q       <= '0;
      vld_q       <= 1'b0;
      eor_q       <= 1'b0;
      eof_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (acc) begin
        cur_q      <= sb_pix;
        eor_q      <= row_end;
        eof_q      <= sb_eof;
        win_row_q  <= wr_row_q;
        win_done_q <= rows_done_q;
        mode_q     <= mode_eff;
        vld_q      <= emit;
        if (sb_eof) begin
          col_q       <= '0;
          col_full_q  <= 1'b0;
          wr_row_q    <= '0;
          rows_done_q <= '0;
        end else if (sb_eor) begin
          col_q      <= '0;
          col_full_q <= 1'b0;
          wr_row_q   <= (wr_row_q == PTR_W'(KERNEL_H-1)) ? '0 : wr_row_q + 1'b1;
          if (rows_done_q != PTR_W'(KERNEL_H-1)) rows_done_q <= rows_done_q + 1'b1;
        end else if (col_q == COL_W'(MAX_IMG_W-1)) begin
          // Past the last address further pixels keep overwriting it.
          col_full_q <= 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else if (bus.i_rdy) begin
        vld_q <= 1'b0;
      end
      ovf_q <= (ovf_q && !(vld_q && bus.i_rdy && eof_q)) || (acc && col_full_q);
    end
  end

  line_buffer_pad_mux #(.PIX_W(PIX_W), .KERNEL_H(KERNEL_H), .PTR_W(PTR_W)) u_mux (
    .i_bank(bank_rd),
    .i_cur (cur_q),
    .i_row (win_row_q),
    .i_done(win_done_q),
    .i_mode(mode_q),
    .o_win (win)
  );

  assign bus.o_vld  = vld_q;
  assign bus.o_eor  = eor_q;
  assign bus.o_eof  = eof_q;
  assign bus.o_ovf  = ovf_q;
  assign bus.o_data = win;
endmodule

// File: tb/tb_line_buffer_mc.sv
// Directed bench: table of frames through a 3-tall, 4-wide line buffer plus reset corners.
module tb_line_buffer_mc;
  import line_buffer_pkg::*;

  localparam int DW = 8, CH = 3, KH = 3, MAXW = 4;
  localparam int PW = DW * CH, WW = KH * PW;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;
  always #5 i_clk = ~i_clk;

  line_buffer_mc_if #(.DATA_W(DW), .CHANNELS(CH), .KERNEL_H(KH)) bus ();

  line_buffer_mc #(.DATA_W(DW), .CHANNELS(CH), .KERNEL_H(KH), .MAX_IMG_W(MAXW)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  int checks = 0, errors = 0;

  typedef struct {
    int mode;
    int rows;
    int cols;
    int thr;
    int exp_n;
  } case_t;

  typedef struct {
    logic [WW-1:0] data;
    logic          eor, eof, ovf;
  } win_t;

  task automatic chk(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(int r, int c);
    int v;
    v = r * 16 + c;
    return {8'(v + 129), 8'(v + 65), 8'(v + 1)};
  endfunction

  // Slot k holds frame row r-(KH-1-k); rows above the frame are zero or row 0.
  function automatic logic [WW-1:0] exp_win(int mode, int r, int c);
    logic [KH-1:0][PW-1:0] w;
    w = '0;
    for (int k = 0; k < KH; k++) begin
      int src;
      src = r - (KH - 1 - k);
      if (src >= 0)       w[k] = pix(src, c);
      else if (mode == 2) w[k] = pix(0, c);
    end
    return w;
  endfunction

  task automatic run_frame(case_t tc, string tag);
    win_t q[$];
    win_t w;
    int   npix, sent, got, cyc;
    bit   ovf_s;
    npix = tc.rows * tc.cols; sent = 0; got = 0; cyc = 0; ovf_s = 0;
    for (int r = 0; r < tc.rows; r++)
      for (int c = 0; c < tc.cols; c++) begin
        if (c >= MAXW) ovf_s = 1;
        if (tc.mode != 0 || r >= KH - 1) begin
          w.data = exp_win(tc.mode, r, c);
          w.eor  = (c == tc.cols - 1);
          w.eof  = (r == tc.rows - 1) && (c == tc.cols - 1);
          w.ovf  = ovf_s;
          q.push_back(w);
        end
      end
    bus.i_pad_mode = 2'(tc.mode);
    while ((sent < npix || q.size() != 0) && cyc < 2000) begin
      @(negedge i_clk);
      cyc++;
      if (sent >= 1) bus.i_pad_mode = 2'((tc.mode + 1) % 4);
      bus.i_rdy = (tc.thr == 0) || ($urandom_range(99) >= tc.thr);
      if (bus.o_vld) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s extra: got window %0h expected none", tag, bus.o_data);
        end else begin
          w = q[0];
          chk({tag, " data"}, bus.o_data, w.data);
          chk({tag, " flags"}, {bus.o_eor, bus.o_eof, bus.o_ovf}, {w.eor, w.eof, w.ovf});
          if (bus.i_rdy) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (sent < npix && (tc.thr == 0 || $urandom_range(99) >= tc.thr)) begin
        bus.i_vld  = 1'b1;
        bus.i_data = pix(sent / tc.cols, sent % tc.cols);
        bus.i_eor  = ((sent % tc.cols) == tc.cols - 1);
        bus.i_eof  = (sent == npix - 1);
        if (bus.o_rdy) sent++;
      end else begin
        bus.i_vld  = 1'b0;
        bus.i_data = PW'($urandom);
        bus.i_eor  = 1'($urandom);
        bus.i_eof  = 1'($urandom);
      end
    end
    if (cyc >= 2000) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d windows expected %0d", tag, got, tc.exp_n);
    end
    chk({tag, " count"}, got, tc.exp_n);
    if (tc.thr == 0) chk({tag, " cycles"}, cyc, npix + 1);
    bus.i_vld = 1'b0;
    bus.i_rdy = 1'b1;
    @(negedge i_clk);
    chk({tag, " idle vld/ovf"}, {bus.o_vld, bus.o_ovf}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    case_t tbl[9];
    int    p, cyc, r, c;
    tbl[0] = '{1, 4, 4, 0, 16};   // zero pad
    tbl[1] = '{2, 4, 4, 0, 16};   // replicate
    tbl[2] = '{0, 4, 4, 0, 8};    // legacy suppression
    tbl[3] = '{1, 4, 4, 30, 16};
    tbl[4] = '{2, 4, 4, 30, 16};
    tbl[5] = '{0, 4, 4, 30, 8};
    tbl[6] = '{3, 4, 4, 0, 16};   // reserved encoding acts as zero pad
    tbl[7] = '{1, 1, 6, 0, 6};    // row longer than MAX_IMG_W
    tbl[8] = '{2, 4, 4, 0, 16};   // clean frame after overflow

    bus.i_pad_mode = 2'd0; bus.i_vld = 1'b0; bus.i_eor = 1'b0;
    bus.i_eof = 1'b0; bus.i_data = '0; bus.i_rdy = 1'b0;
    #1 i_rst_n = 1'b0;
    #2 chk("reset outputs", {bus.o_vld, bus.o_eor, bus.o_eof, bus.o_ovf, bus.o_rdy}, 5'b0);
    @(negedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    #1 chk("rdy before first clock", bus.o_rdy, 1'b0);
    @(negedge i_clk) chk("rdy after first clock", bus.o_rdy, 1'b1);

    for (int i = 0; i < 9; i++) run_frame(tbl[i], $sformatf("case%0d", i));

    // Two full rows, then an overflowing partial third row cut by reset.
    bus.i_rdy = 1'b1; bus.i_pad_mode = 2'd1; p = 0; cyc = 0;
    while (p < 13 && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
      r = (p < 8) ? p / 4 : 2;
      c = (p < 8) ? p % 4 : p - 8;
      bus.i_vld  = 1'b1;
      bus.i_data = pix(r, c);
      bus.i_eor  = (p < 8) && (c == 3);
      bus.i_eof  = 1'b0;
      if (bus.o_rdy) p++;
    end
    @(negedge i_clk);
    bus.i_vld = 1'b0;
    chk("ovf in row 2", {bus.o_vld, bus.o_ovf}, 2'b11);
    i_rst_n = 1'b0;
    #1 chk("async reset mid-row", {bus.o_vld, bus.o_eor, bus.o_eof, bus.o_ovf, bus.o_rdy}, 5'b0);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(negedge i_clk) chk("rdy after mid reset", bus.o_rdy, 1'b1);
    run_frame('{1, 4, 4, 0, 16}, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
